hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 70 +++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and stall/flush/mul-div outputs
interface hazard_ctrl_if;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       ID_Branch;
  logic       Branch_Taken;
  logic       ID_EX_MemRead;
  logic       ID_EX_RegWrite;
  logic [4:0] ID_EX_Rd;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_Rd;
  logic       ID_MD_Op;
  logic       ID_HiLo_Read;
  logic       ID_EX_MD_Op;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       MD_Start;
  logic       MD_Busy;
  logic       MD_Done;
  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite,
           ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd, ID_MD_Op, ID_HiLo_Read, ID_EX_MD_Op,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, MD_Done
  );
  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite,
           ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd, ID_MD_Op, ID_HiLo_Read, ID_EX_MD_Op,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, MD_Done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with optional mul/div busy tracker (HAZARD_CTRL_MULDIV_EN)
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave h
);
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, br_alu, br_load, md_hz, stall;
  logic md_start, md_busy, md_done;
  assign rs_ex    = h.ID_EX_Rd != 5'd0 && h.ID_EX_Rd == h.IF_ID_Rs;
  assign rt_ex    = h.ID_EX_Rd != 5'd0 && h.ID_EX_Rd == h.IF_ID_Rt;
  assign rs_mem   = h.EX_MEM_Rd != 5'd0 && h.EX_MEM_Rd == h.IF_ID_Rs;
  assign rt_mem   = h.EX_MEM_Rd != 5'd0 && h.EX_MEM_Rd == h.IF_ID_Rt;
  assign load_use = h.ID_EX_MemRead && (rs_ex || rt_ex);
  assign br_alu   = h.ID_Branch && h.ID_EX_RegWrite && (rs_ex || rt_ex);
  assign br_load  = h.ID_Branch && h.EX_MEM_MemRead && (rs_mem || rt_mem);
  assign stall    = load_use || br_alu || br_load || md_hz;
`ifdef HAZARD_CTRL_MULDIV_EN
  typedef enum logic {IDLE, BUSY} md_state_t;
  md_state_t  state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;
  logic       unused_clk;
  assign unused_clk = 1'b0;
  // mul/div state and countdown register, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end
  // start in IDLE, count down while BUSY, pulse done on the last busy cycle
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_start = rst_n && state_q == IDLE && h.ID_EX_MD_Op;
    md_busy  = state_q == BUSY;
    md_done  = md_busy && md_cnt_q == 6'd0;
    if (md_start) begin
      state_d  = BUSY;
      md_cnt_d = 6'(MD_LAT - 1);
    end else if (md_busy) begin
      state_d  = md_done ? IDLE : BUSY;
      md_cnt_d = md_done ? 6'd0 : md_cnt_q - 6'd1;
    end
  end
  assign md_hz = md_busy && (h.ID_MD_Op || h.ID_HiLo_Read);
`else
  logic unused_md;
  assign unused_md = ^{clk, h.ID_MD_Op, h.ID_HiLo_Read, h.ID_EX_MD_Op, 6'(MD_LAT)};
  assign md_start  = 1'b0;
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
  assign md_hz     = 1'b0;
`endif
  // stall beats taken-branch flush; reset holds the front end frozen and flushed
  always_comb begin
    h.PC_Write    = rst_n && !stall;
    h.IF_ID_Write = rst_n && !stall;
    h.IF_ID_Flush = !rst_n || (!stall && h.Branch_Taken);
    h.ID_EX_Flush = !rst_n || stall;
    h.MD_Start    = md_start;
    h.MD_Busy     = md_busy;
    h.MD_Done     = md_done;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a cycle-indexed model
module tb_hazard_ctrl;
  localparam int LAT = 4;
`ifdef HAZARD_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0, fails = 0, cyc = 0, md_s = -1000;
  always #5 clk = ~clk;
  hazard_ctrl_if h();
  hazard_ctrl #(.MD_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .h(h));

  task automatic check(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    h.IF_ID_Rs = 0; h.IF_ID_Rt = 0; h.ID_Branch = 0; h.Branch_Taken = 0;
    h.ID_EX_MemRead = 0; h.ID_EX_RegWrite = 0; h.ID_EX_Rd = 0;
    h.EX_MEM_MemRead = 0; h.EX_MEM_Rd = 0;
    h.ID_MD_Op = 0; h.ID_HiLo_Read = 0; h.ID_EX_MD_Op = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // reference model: the unit is busy on cycles md_s+1 .. md_s+LAT after a start at md_s
  always @(negedge clk) begin
    logic busy, done, start, hz, dep_ex, dep_mem;
    if (!rst_n) md_s = -1000;
    busy    = MD_EN && rst_n && cyc > md_s && cyc <= md_s + LAT;
    done    = busy && cyc == md_s + LAT;
    start   = MD_EN && rst_n && !busy && h.ID_EX_MD_Op;
    dep_ex  = h.ID_EX_Rd != 0 && (h.ID_EX_Rd == h.IF_ID_Rs || h.ID_EX_Rd == h.IF_ID_Rt);
    dep_mem = h.EX_MEM_Rd != 0 && (h.EX_MEM_Rd == h.IF_ID_Rs || h.EX_MEM_Rd == h.IF_ID_Rt);
    hz = (h.ID_EX_MemRead && dep_ex) || (h.ID_Branch && h.ID_EX_RegWrite && dep_ex)
       || (h.ID_Branch && h.EX_MEM_MemRead && dep_mem) || (busy && (h.ID_MD_Op || h.ID_HiLo_Read));
    if (start) md_s = cyc;
    check("PC_Write", h.PC_Write, rst_n && !hz);
    check("IF_ID_Write", h.IF_ID_Write, rst_n && !hz);
    check("IF_ID_Flush", h.IF_ID_Flush, !rst_n || (!hz && h.Branch_Taken));
    check("ID_EX_Flush", h.ID_EX_Flush, !rst_n || hz);
    check("MD_Start", h.MD_Start, start);
    check("MD_Busy", h.MD_Busy, busy);
    check("MD_Done", h.MD_Done, done);
  end

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_pc", h.PC_Write, 1'b0);
    check("rst_ifid_flush", h.IF_ID_Flush, 1'b1);
    check("rst_idex_flush", h.ID_EX_Flush, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    // load-use on Rt
    h.ID_EX_MemRead = 1; h.ID_EX_Rd = 5; h.IF_ID_Rt = 5;
    @(negedge clk);
    check("lu_pc", h.PC_Write, 1'b0);
    check("lu_ifid_wr", h.IF_ID_Write, 1'b0);
    check("lu_idex_flush", h.ID_EX_Flush, 1'b1);
    // taken branch under stall does not flush IF/ID
    tick();
    h.Branch_Taken = 1;
    @(negedge clk);
    check("lu_br_ifid_flush", h.IF_ID_Flush, 1'b0);
    check("lu_br_idex_flush", h.ID_EX_Flush, 1'b1);
    // register 0 never hazards
    tick();
    h.Branch_Taken = 0; h.ID_EX_Rd = 0; h.IF_ID_Rt = 0;
    @(negedge clk);
    check("r0_pc", h.PC_Write, 1'b1);
    // branch after load to $8: two stalls, then taken flush
    tick();
    clear_inputs();
    h.ID_Branch = 1; h.IF_ID_Rs = 8;
    h.ID_EX_MemRead = 1; h.ID_EX_RegWrite = 1; h.ID_EX_Rd = 8;
    @(negedge clk);
    check("bl_stall1", h.PC_Write, 1'b0);
    tick();
    h.ID_EX_MemRead = 0; h.ID_EX_RegWrite = 0; h.ID_EX_Rd = 0;
    h.EX_MEM_MemRead = 1; h.EX_MEM_Rd = 8;
    @(negedge clk);
    check("bl_stall2", h.ID_EX_Flush, 1'b1);
    tick();
    h.EX_MEM_MemRead = 0; h.EX_MEM_Rd = 0; h.Branch_Taken = 1;
    @(negedge clk);
    check("bl_go_pc", h.PC_Write, 1'b1);
    check("bl_go_flush", h.IF_ID_Flush, 1'b1);
    tick();
    clear_inputs();
`ifdef HAZARD_CTRL_MULDIV_EN
    h.ID_EX_MD_Op = 1;
    @(negedge clk);
    check("md_start", h.MD_Start, 1'b1);
    tick();
    h.ID_EX_MD_Op = 0; h.ID_HiLo_Read = 1;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check("md_busy", h.MD_Busy, 1'b1);
      check("md_hilo_stall", h.PC_Write, 1'b0);
      check("md_done", h.MD_Done, i == LAT);
      tick();
    end
    @(negedge clk);
    check("md_release_pc", h.PC_Write, 1'b1);
    check("md_release_busy", h.MD_Busy, 1'b0);
    tick();
    h.ID_HiLo_Read = 0; h.ID_EX_MD_Op = 1;
    tick();
    h.ID_EX_MD_Op = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("md_rst_busy", h.MD_Busy, 1'b0);
    check("md_rst_done", h.MD_Done, 1'b0);
    check("md_rst_flush", h.IF_ID_Flush, 1'b1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("md_post_rst_busy", h.MD_Busy, 1'b0);
    tick();
`else
    h.ID_EX_MD_Op = 1; h.ID_HiLo_Read = 1; h.ID_MD_Op = 1;
    @(negedge clk);
    check("nomd_start", h.MD_Start, 1'b0);
    check("nomd_pc", h.PC_Write, 1'b1);
    tick();
    @(negedge clk);
    check("nomd_busy", h.MD_Busy, 1'b0);
    tick();
`endif
    for (int n = 0; n < 2000; n++) begin
      h.IF_ID_Rs       = 5'($urandom_range(0, 3));
      h.IF_ID_Rt       = 5'($urandom_range(0, 3));
      h.ID_EX_Rd       = 5'($urandom_range(0, 3));
      h.EX_MEM_Rd      = 5'($urandom_range(0, 3));
      h.ID_Branch      = 1'($urandom);
      h.Branch_Taken   = 1'($urandom);
      h.ID_EX_MemRead  = 1'($urandom);
      h.ID_EX_RegWrite = 1'($urandom);
      h.EX_MEM_MemRead = 1'($urandom);
      h.ID_MD_Op       = $urandom_range(0, 3) == 0;
      h.ID_HiLo_Read   = $urandom_range(0, 3) == 0;
      h.ID_EX_MD_Op    = $urandom_range(0, 5) == 0;
      rst_n            = $urandom_range(0, 149) != 0;
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
